// File: rtl/shift_pkg.sv
// Shared types and defaults for the shift register and its sequencer.
// State encoding is common to the controller and any debug observers.
package shift_pkg;

  localparam int SIZE_DEF  = 16;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/shift_reg.sv
// Loadable shift register: parallel load, or one shift step per pulse.
// Direction and fill mode are fixed at elaboration.
module shift_reg
  import shift_pkg::*;
#(
  parameter int SIZE         = SIZE_DEF,
  parameter int SHIFT_AMOUNT = 4,
  parameter bit RIGHT        = 1'b1,
  parameter bit ARITH        = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic [SIZE-1:0] din_i,
  input  logic            wr_en_i,
  input  logic            shift_i,
  output logic [SIZE-1:0] dout_o
);

  logic [SIZE-1:0] q_q;
  logic [SIZE-1:0] q_d;
  logic [SIZE-1:0] sh;

  always_comb begin
    sh = q_q << SHIFT_AMOUNT;
    if (RIGHT) begin
      if (ARITH) sh = $signed(q_q) >>> SHIFT_AMOUNT;
      else       sh = q_q >> SHIFT_AMOUNT;
    end
  end

  always_comb begin
    q_d = q_q;
    if (wr_en_i)      q_d = din_i;
    else if (shift_i) q_d = sh;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) q_q <= '0;
    else           q_q <= q_d;
  end

  assign dout_o = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: one load then N shift pulses into a shift_reg,
// optional idle gap between pulses, result on a valid/ready port.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int SIZE      = SIZE_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PULSE_GAP = 0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [SIZE-1:0]  req_data_i,
  input  logic [CNT_W-1:0] req_cnt_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [SIZE-1:0]  resp_data_o,
  output logic             busy_o,
  output logic [SIZE-1:0]  sr_din_o,
  output logic             sr_wr_en_o,
  output logic             sr_shift_o,
  input  logic [SIZE-1:0]  sr_dout_i
);

  localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam bit HAS_GAP = (PULSE_GAP > 0);
  localparam logic [GAP_W-1:0] GAP_LD =
    GAP_W'(HAS_GAP ? PULSE_GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [SIZE-1:0]  data_q, data_d;
  logic             req_hs;

  assign req_hs = req_valid_i & (state_q == ST_IDLE);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          state_d = ST_LOAD;
          rem_d   = req_cnt_i;
          data_d  = req_data_i;
        end
      end
      ST_LOAD: begin
        state_d = (rem_q == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else if (HAS_GAP) begin
          state_d = ST_GAP;
          gap_d   = GAP_LD;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_SHIFT;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      ST_DONE: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // abort beats any handshake; latched data is kept
    if (flush_i) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      gap_d   = '0;
      data_d  = data_q;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == ST_IDLE);
    busy_o       = (state_q != ST_IDLE);
    sr_wr_en_o   = (state_q == ST_LOAD);
    sr_shift_o   = (state_q == ST_SHIFT);
    resp_valid_o = (state_q == ST_DONE);
    resp_data_o  = resp_valid_o ? sr_dout_i : '0;
    sr_din_o     = data_q;
  end

endmodule
